ext_buf_loader: RTL and testbench

Loader that fills the systolic system's A or W operand buffer from an external 32-bit BRAM. It is the writer side of the buffer external-write port: it drives `ram_w_data` / `ram_w_addr` and a one-hot per-bank write enable, which connect directly to `a_ram_w_*` or `w_ram_w_*`. On a single `start` pulse it walks a row-major tile in external memory and delivers every element to the correct bank and address. It raises `busy` while running and pulses `done` when the last write has been issued.

---
 rtl/ext_buf_loader.sv | 170 +++++++++++++++++
 tb/tb_ext_buf_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_buf_loader.sv
// Loader that streams a row-major tile from an external 32-bit BRAM into the
// A or W operand buffer through its one-hot per-bank external write port.
module ext_buf_loader #(
  parameter int unsigned ARRAY_N        = 16,
  parameter int unsigned ARRAY_M        = 16,
  parameter int unsigned RAM_SIZE       = 1024,
  parameter int unsigned ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int unsigned EXT_ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        sel,
  input  logic [$clog2(ARRAY_N):0]    num_banks,
  input  logic [ADDR_WIDTH:0]         depth,
  input  logic [EXT_ADDR_WIDTH-1:0]   ext_base_addr,
  input  logic [ADDR_WIDTH-1:0]       buf_base_addr,
  output logic                        ext_rd_en,
  output logic [EXT_ADDR_WIDTH-1:0]   ext_rd_addr,
  input  logic [31:0]                 ext_rd_data,
  output logic [31:0]                 ram_w_data,
  output logic [ADDR_WIDTH-1:0]       ram_w_addr,
  output logic [ARRAY_N-1:0]          a_ram_w_en,
  output logic [ARRAY_M-1:0]          w_ram_w_en,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned MAXB = (ARRAY_N > ARRAY_M) ? ARRAY_N : ARRAY_M;
  localparam int unsigned CW   = $clog2(MAXB) + 1;
  localparam int unsigned DW   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t                state;
  logic                  sel_lat;
  logic [CW-1:0]         nb_lat;
  logic [DW-1:0]         depth_lat;
  logic [ADDR_WIDTH-1:0] buf_base_lat;
  logic [CW-1:0]         rd_bank;
  logic [DW-1:0]         rd_k;
  logic [ADDR_WIDTH-1:0] rd_buf;
  logic                  drain_cnt;

  logic [CW-1:0]         nb_req;
  logic [CW-1:0]         nb_lim;
  logic [CW-1:0]         nb_eff;
  logic                  last_k;
  logic                  last_bank;
  logic [ADDR_WIDTH-1:0] next_buf;

  logic                  s1_valid;
  logic [CW-1:0]         s1_bank;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [ARRAY_N-1:0]    a_onehot;
  logic [ARRAY_M-1:0]    w_onehot;

  always_comb begin
    nb_req    = CW'(num_banks);
    nb_lim    = sel ? CW'(ARRAY_M) : CW'(ARRAY_N);
    nb_eff    = (nb_req > nb_lim) ? nb_lim : nb_req;
    last_k    = (rd_k == depth_lat - DW'(1));
    last_bank = (rd_bank == nb_lat - CW'(1));
    next_buf  = (rd_buf == LAST_ADDR) ? '0 : rd_buf + ADDR_WIDTH'(1);
    a_onehot  = ARRAY_N'(1) << s1_bank;
    w_onehot  = ARRAY_M'(1) << s1_bank;
  end

  // The issue registers hold the element currently on the read port; the
  // external address simply counts up since traversal is row-major.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sel_lat      <= 1'b0;
      nb_lat       <= '0;
      depth_lat    <= '0;
      buf_base_lat <= '0;
      rd_bank      <= '0;
      rd_k         <= '0;
      rd_buf       <= '0;
      drain_cnt    <= 1'b0;
      ext_rd_en    <= 1'b0;
      ext_rd_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_lat      <= sel;
            nb_lat       <= nb_eff;
            depth_lat    <= depth;
            buf_base_lat <= buf_base_addr;
            rd_bank      <= '0;
            rd_k         <= '0;
            rd_buf       <= buf_base_addr;
            ext_rd_addr  <= ext_base_addr;
            busy         <= 1'b1;
            if (nb_eff == '0 || depth == '0) begin
              state <= FIN;
            end else begin
              ext_rd_en <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (last_k && last_bank) begin
            ext_rd_en <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            ext_rd_addr <= ext_rd_addr + EXT_ADDR_WIDTH'(1);
            if (last_k) begin
              rd_k    <= '0;
              rd_bank <= rd_bank + CW'(1);
              rd_buf  <= buf_base_lat;
            end else begin
              rd_k   <= rd_k + DW'(1);
              rd_buf <= next_buf;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        FIN: begin
          // Empty transfers arrive here with done still low and spend one
          // busy cycle before the pulse; drained transfers arrive with it set.
          if (!done) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_bank    <= '0;
      s1_addr    <= '0;
      a_ram_w_en <= '0;
      w_ram_w_en <= '0;
      ram_w_addr <= '0;
      ram_w_data <= '0;
    end else begin
      s1_valid   <= ext_rd_en;
      s1_bank    <= rd_bank;
      s1_addr    <= rd_buf;
      a_ram_w_en <= (s1_valid && !sel_lat) ? a_onehot : '0;
      w_ram_w_en <= (s1_valid &&  sel_lat) ? w_onehot : '0;
      ram_w_addr <= s1_addr;
      ram_w_data <= ext_rd_data;
    end
  end

endmodule

// File: tb/tb_ext_buf_loader.sv
// Directed bench for ext_buf_loader: a per-cycle schedule model built from the
// address mapping and cycle budget of each transfer, plus literal spot checks.
module tb_ext_buf_loader;
  localparam int NCYC = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel;
  logic [4:0]  num_banks;
  logic [10:0] depth;
  logic [15:0] ext_base_addr;
  logic [9:0]  buf_base_addr;
  logic        ext_rd_en;
  logic [15:0] ext_rd_addr;
  logic [31:0] ext_rd_data;
  logic [31:0] ram_w_data;
  logic [9:0]  ram_w_addr;
  logic [15:0] a_ram_w_en;
  logic [15:0] w_ram_w_en;
  logic        busy;
  logic        done;

  ext_buf_loader #(
    .ARRAY_N(16), .ARRAY_M(16), .RAM_SIZE(1024), .EXT_ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel),
    .num_banks(num_banks), .depth(depth),
    .ext_base_addr(ext_base_addr), .buf_base_addr(buf_base_addr),
    .ext_rd_en(ext_rd_en), .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
    .ram_w_data(ram_w_data), .ram_w_addr(ram_w_addr),
    .a_ram_w_en(a_ram_w_en), .w_ram_w_en(w_ram_w_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [15:0] a);
    return {a ^ 16'hC3C3, a};
  endfunction

  // External BRAM: one-cycle read latency, garbage when not reading.
  always @(posedge clk) ext_rd_data <= ext_rd_en ? mem(ext_rd_addr) : 32'hDEAD_BEEF;

  logic        e_rd_en  [NCYC];
  logic [15:0] e_rd_addr[NCYC];
  logic [15:0] e_a_en   [NCYC];
  logic [15:0] e_w_en   [NCYC];
  logic [9:0]  e_waddr  [NCYC];
  logic [31:0] e_wdata  [NCYC];
  logic        e_busy   [NCYC];
  logic        e_done   [NCYC];
  int free_at = 0;

  int nvec = 0;
  int nmis = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_clear_from(input int c);
    for (int i = c; i < NCYC; i++) begin
      e_rd_en[i] = 1'b0; e_rd_addr[i] = '0; e_a_en[i] = '0; e_w_en[i] = '0;
      e_waddr[i] = '0;   e_wdata[i] = '0;   e_busy[i] = 1'b0; e_done[i] = 1'b0;
    end
  endfunction

  // Element i of a transfer: read at s+1+i, written at s+3+i.
  function automatic void model_start(input int s, input int sl, input int nb,
                                      input int dep, input int eb, input int bb);
    int ne, e, r, k, c;
    logic [15:0] a;
    logic [15:0] one;
    if (s < free_at) return;
    ne = (nb > 16) ? 16 : nb;
    e  = ne * dep;
    one = 16'h0001;
    if (e == 0) begin
      e_busy[s+1] = 1'b1;
      e_done[s+2] = 1'b1;
      free_at = s + 3;
      return;
    end
    for (int i = 0; i < e; i++) begin
      r = i / dep;
      k = i % dep;
      a = 16'((eb + r * dep + k) % 65536);
      e_rd_en[s+1+i]   = 1'b1;
      e_rd_addr[s+1+i] = a;
      c = s + 3 + i;
      if (sl == 0) e_a_en[c] = one << r;
      else         e_w_en[c] = one << r;
      e_waddr[c] = 10'((bb + k) % 1024);
      e_wdata[c] = mem(a);
    end
    for (int i = s + 1; i <= s + e + 2; i++) e_busy[i] = 1'b1;
    e_done[s+e+3] = 1'b1;
    free_at = s + e + 4;
  endfunction

  always @(negedge clk) begin
    if (chk_on && cyc < NCYC) begin
      chk("rd_en", {31'b0, ext_rd_en}, {31'b0, e_rd_en[cyc]});
      if (e_rd_en[cyc]) chk("rd_addr", {16'b0, ext_rd_addr}, {16'b0, e_rd_addr[cyc]});
      chk("a_en", {16'b0, a_ram_w_en}, {16'b0, e_a_en[cyc]});
      chk("w_en", {16'b0, w_ram_w_en}, {16'b0, e_w_en[cyc]});
      if ((e_a_en[cyc] | e_w_en[cyc]) != 16'h0) begin
        chk("w_addr", {22'b0, ram_w_addr}, {22'b0, e_waddr[cyc]});
        chk("w_data", ram_w_data, e_wdata[cyc]);
      end
      chk("busy", {31'b0, busy}, {31'b0, e_busy[cyc]});
      chk("done", {31'b0, done}, {31'b0, done_exp(cyc)});
    end
  end

  function automatic logic done_exp(input int c);
    return e_done[c];
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_xfer(input int sl, input int nb, input int dep,
                            input int eb, input int bb);
    sel           = sl[0];
    num_banks     = nb[4:0];
    depth         = dep[10:0];
    ext_base_addr = eb[15:0];
    buf_base_addr = bb[9:0];
    start         = 1'b1;
    model_start(cyc, sl, nb, dep, eb, bb);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},  {31'b0, ext_rd_en}, 32'h0);
    chk({tag, "_rd_addr"}, {16'b0, ext_rd_addr}, 32'h0);
    chk({tag, "_a_en"},   {16'b0, a_ram_w_en}, 32'h0);
    chk({tag, "_w_en"},   {16'b0, w_ram_w_en}, 32'h0);
    chk({tag, "_w_addr"}, {22'b0, ram_w_addr}, 32'h0);
    chk({tag, "_w_data"}, ram_w_data, 32'h0);
    chk({tag, "_busy"},   {31'b0, busy}, 32'h0);
    chk({tag, "_done"},   {31'b0, done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  int s;

  initial begin
    reset = 1'b0; start = 1'b0; sel = 1'b0; num_banks = '0; depth = '0;
    ext_base_addr = '0; buf_base_addr = '0;
    model_clear_from(0);
    chk_on = 1'b1;
    goto(2);
    @(negedge clk);
    chk_all_zero("rst");
    goto(3);
    reset = 1'b1;
    goto(5);

    // A load
    s = cyc;
    begin_xfer(0, 2, 3, 16'h10, 5);
    chk("m_t1_addr", {22'b0, e_waddr[s+3]}, 32'd5);
    chk("m_t1_data", e_wdata[s+8], 32'hC3D6_0015);
    goto(s + 3); @(negedge clk);
    chk("t1_first_en",   {16'b0, a_ram_w_en}, 32'h0001);
    chk("t1_first_addr", {22'b0, ram_w_addr}, 32'd5);
    chk("t1_first_data", ram_w_data, 32'hC3D3_0010);
    goto(s + 8); @(negedge clk);
    chk("t1_last_en",   {16'b0, a_ram_w_en}, 32'h0002);
    chk("t1_last_addr", {22'b0, ram_w_addr}, 32'd7);
    goto(s + 9); @(negedge clk);
    chk("t1_done", {31'b0, done}, 32'h1);

    // W load with buffer and external address wrap, started back-to-back
    goto(free_at);
    s = cyc;
    begin_xfer(1, 1, 4, 16'hFFFE, 1022);
    goto(s + 3); @(negedge clk);
    chk("t2_ext_wrap", {16'b0, ext_rd_addr}, 32'h0000);
    goto(s + 5); @(negedge clk);
    chk("t2_wrap_addr", {22'b0, ram_w_addr}, 32'd0);
    chk("t2_w_en",      {16'b0, w_ram_w_en}, 32'h0001);
    chk("t2_data",      ram_w_data, 32'hC3C3_0000);

    // Clamp: 17 banks requested, 16 delivered
    goto(free_at);
    s = cyc;
    begin_xfer(0, 17, 1, 16'h200, 0);
    goto(s + 18); @(negedge clk);
    chk("t3_last_en", {16'b0, a_ram_w_en}, 32'h8000);
    goto(s + 19); @(negedge clk);
    chk("t3_done", {31'b0, done}, 32'h1);

    // Empty transfer
    goto(free_at);
    s = cyc;
    begin_xfer(1, 3, 0, 16'h300, 0);
    goto(s + 2); @(negedge clk);
    chk("t4_done", {31'b0, done}, 32'h1);

    // Reset in the middle of an A load, then a clean rerun
    goto(free_at + 2);
    s = cyc;
    begin_xfer(0, 2, 3, 16'h10, 5);
    goto(s + 4);
    #1;
    reset = 1'b0;
    model_clear_from(s + 4);
    free_at = s + 4;
    #1;
    chk_all_zero("midrst");
    goto(s + 6);
    reset = 1'b1;
    goto(s + 7);
    s = cyc;
    begin_xfer(0, 2, 3, 16'h10, 5);
    goto(s + 9); @(negedge clk);
    chk("t5_done", {31'b0, done}, 32'h1);

    // Start pulsed while busy with different parameters is ignored
    goto(free_at);
    s = cyc;
    begin_xfer(0, 2, 3, 16'h40, 10);
    goto(s + 2);
    begin_xfer(1, 4, 5, 16'h100, 0);
    goto(s + 9); @(negedge clk);
    chk("t6_done", {31'b0, done}, 32'h1);
    chk("t6_w_en_idle", {16'b0, w_ram_w_en}, 32'h0);

    goto(free_at + 4);
    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
